// File: rtl/dcache_port_arbiter.sv
// ---------------------------------------------------------------------------
// DcachePortArbiter (module dcache_port_arbiter)
//
// Purpose:
//   Shares the single dcache request port between NUM_LD load units and the
//   committed-store path. Stores normally win, loads are served round-robin,
//   and a streak counter caps how many stores in a row may be granted while
//   a load is waiting. Only one dcache access is outstanding at a time; the
//   response is routed back to whichever requester was granted.
//
// Ports:
//   clock              rising-edge system clock
//   reset              asynchronous, active-low reset (0 = in reset)
//   ld_req             per-load request, held until that unit sees ld_valid
//   ld_addr            per-load byte address, slice i = [i*XLEN +: XLEN]
//   st_req             store request, held until st_ack
//   st_addr            store byte address
//   st_data            store word
//   st_size            store size (0=BYTE, 1=HALF, 2=WORD)
//   squash             pipeline flush, kills an in-flight load
//   Dcache_data_out    dcache response doubleword
//   Dcache_valid_out   dcache access complete (load or store)
//   arb2Dcache_command 0=NONE, 1=LOAD, 2=STORE
//   arb2Dcache_addr    access address
//   arb2Dcache_data    store doubleword (word placed by address bit 2)
//   arb2Dcache_size    access size
//   ld_data            Dcache_data_out passed straight through to all loads
//   ld_valid           one-hot completion pulse for the granted load
//   st_ack             completion pulse for the store
//   busy               high whenever an access is in progress
// ---------------------------------------------------------------------------
module dcache_port_arbiter #(
    parameter int NUM_LD       = 2,
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_LD-1:0]      ld_req,
    input  logic [NUM_LD*XLEN-1:0] ld_addr,
    input  logic                   st_req,
    input  logic [XLEN-1:0]        st_addr,
    input  logic [XLEN-1:0]        st_data,
    input  logic [1:0]             st_size,
    input  logic                   squash,
    input  logic [63:0]            Dcache_data_out,
    input  logic                   Dcache_valid_out,
    output logic [1:0]             arb2Dcache_command,
    output logic [XLEN-1:0]        arb2Dcache_addr,
    output logic [63:0]            arb2Dcache_data,
    output logic [1:0]             arb2Dcache_size,
    output logic [63:0]            ld_data,
    output logic [NUM_LD-1:0]      ld_valid,
    output logic                   st_ack,
    output logic                   busy
);

    localparam int IDXW = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        ST_WAIT = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDXW-1:0]   r_rr_ptr;
    logic [IDXW-1:0]   r_grant;
    logic [SW-1:0]     r_st_streak;
    logic [XLEN-1:0]   r_addr;
    logic [63:0]       r_data;
    logic [1:0]        r_size;

    logic [NUM_LD-1:0] w_ld_eff;
    logic              w_any_ld;
    logic              w_st_win;
    logic              w_ld_found;
    logic [IDXW-1:0]   w_ld_idx;
    logic [IDXW-1:0]   w_cand;
    logic [XLEN-1:0]   w_ld_addr;
    logic [63:0]       w_st_word;
    logic [63:0]       w_st_pos;
    logic [1:0]        w_command;
    logic [NUM_LD-1:0] w_ld_valid;
    logic              w_st_ack;

    // Winner selection while idle. A squash hides every load request for
    // that cycle, so it also cannot trigger the starvation override. The
    // round-robin scan wraps by truncation because NUM_LD is a power of two.
    always_comb begin
        w_ld_eff   = squash ? '0 : ld_req;
        w_any_ld   = |w_ld_eff;
        w_st_win   = st_req && !((r_st_streak == LIMIT) && w_any_ld);
        w_ld_found = 1'b0;
        w_ld_idx   = '0;
        w_cand     = '0;
        for (int k = 0; k < NUM_LD; k++) begin
            w_cand = r_rr_ptr + IDXW'(k);
            if (!w_ld_found && w_ld_eff[w_cand]) begin
                w_ld_found = 1'b1;
                w_ld_idx   = w_cand;
            end
        end
        w_ld_addr = '0;
        for (int j = 0; j < NUM_LD; j++) begin
            if (IDXW'(j) == w_ld_idx) begin
                w_ld_addr = ld_addr[j*XLEN +: XLEN];
            end
        end
        w_st_word = 64'(st_data);
        w_st_pos  = st_addr[2] ? (w_st_word << 32) : w_st_word;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and response pulses. A squash that coincides with the
    // response drops the data and returns straight to IDLE; a squash before
    // the response parks in DRAIN, still presenting LOAD so the dcache can
    // finish the access it already accepted.
    always_comb begin
        w_next     = r_state;
        w_command  = CMD_NONE;
        w_ld_valid = '0;
        w_st_ack   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_st_win) begin
                    w_next = ST_WAIT;
                end else if (w_ld_found) begin
                    w_next = LD_WAIT;
                end
            end
            LD_WAIT: begin
                w_command = CMD_LOAD;
                if (squash) begin
                    w_next = Dcache_valid_out ? IDLE : DRAIN;
                end else if (Dcache_valid_out) begin
                    w_ld_valid[r_grant] = 1'b1;
                    w_next              = IDLE;
                end
            end
            ST_WAIT: begin
                w_command = CMD_STORE;
                if (Dcache_valid_out) begin
                    w_st_ack = 1'b1;
                    w_next   = IDLE;
                end
            end
            DRAIN: begin
                w_command = CMD_LOAD;
                if (Dcache_valid_out) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Grant bookkeeping and the access registers. These only change when a
    // grant is taken, so addr/data/size hold their last values while idle.
    // The store streak only counts stores that overtook a waiting load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_st_streak <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_size      <= '0;
        end else if (r_state == IDLE) begin
            if (w_st_win) begin
                r_addr <= st_addr;
                r_data <= w_st_pos;
                r_size <= st_size;
                if (w_any_ld) begin
                    r_st_streak <= (r_st_streak == LIMIT) ? LIMIT : r_st_streak + SW'(1);
                end else begin
                    r_st_streak <= '0;
                end
            end else if (w_ld_found) begin
                r_grant     <= w_ld_idx;
                r_addr      <= w_ld_addr;
                r_size      <= SIZE_WORD;
                r_rr_ptr    <= w_ld_idx + IDXW'(1);
                r_st_streak <= '0;
            end
        end
    end

    assign arb2Dcache_command = w_command;
    assign arb2Dcache_addr    = r_addr;
    assign arb2Dcache_data    = r_data;
    assign arb2Dcache_size    = r_size;
    assign ld_data            = Dcache_data_out;
    assign ld_valid           = w_ld_valid;
    assign st_ack             = w_st_ack;
    assign busy               = (r_state != IDLE);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// ---------------------------------------------------------------------------
// TbDcachePortArbiter (module tb_dcache_port_arbiter)
//
// Purpose:
//   Self-checking bench for dcache_port_arbiter with the default parameters
//   (NUM_LD=2, XLEN=32, STARVE_LIMIT=4). A table of single transactions is
//   applied back to back (round-robin pointer and store streak carry over
//   between rows), followed by hand-written multi-cycle sequences for
//   round-robin fairness, starvation, squash and mid-access reset.
// ---------------------------------------------------------------------------
module tb_dcache_port_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  ld_req;
    logic [63:0] ld_addr;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        squash;
    logic [63:0] Dcache_data_out;
    logic        Dcache_valid_out;
    logic [1:0]  arb2Dcache_command;
    logic [31:0] arb2Dcache_addr;
    logic [63:0] arb2Dcache_data;
    logic [1:0]  arb2Dcache_size;
    logic [63:0] ld_data;
    logic [1:0]  ld_valid;
    logic        st_ack;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int evLog[8];
    int evCount;

    typedef struct {
        logic [1:0]  ldReq;
        logic [31:0] ldAddr0;
        logic [31:0] ldAddr1;
        logic        stReq;
        logic [31:0] stAddr;
        logic [31:0] stData;
        logic [1:0]  stSize;
        logic [63:0] resp;
        logic [1:0]  expCmd;
        logic [31:0] expAddr;
        logic [63:0] expData;
        logic [1:0]  expSize;
        logic [1:0]  expLdValid;
        logic        expAck;
    } vec_t;

    vec_t vec[10];

    dcache_port_arbiter #(
        .NUM_LD(2),
        .XLEN(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ld_req(ld_req),
        .ld_addr(ld_addr),
        .st_req(st_req),
        .st_addr(st_addr),
        .st_data(st_data),
        .st_size(st_size),
        .squash(squash),
        .Dcache_data_out(Dcache_data_out),
        .Dcache_valid_out(Dcache_valid_out),
        .arb2Dcache_command(arb2Dcache_command),
        .arb2Dcache_addr(arb2Dcache_addr),
        .arb2Dcache_data(arb2Dcache_data),
        .arb2Dcache_size(arb2Dcache_size),
        .ld_data(ld_data),
        .ld_valid(ld_valid),
        .st_ack(st_ack),
        .busy(busy)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Quiet all inputs and pulse reset for two cycles, released at a negedge.
    task automatic doReset();
        reset            = 1'b0;
        ld_req           = '0;
        ld_addr          = '0;
        st_req           = 1'b0;
        st_addr          = '0;
        st_data          = '0;
        st_size          = '0;
        squash           = 1'b0;
        Dcache_data_out  = '0;
        Dcache_valid_out = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Applies one table row as a complete transaction starting from IDLE:
    // request for one edge, check the granted access, return the response,
    // check the completion pulse, then drop requests and check busy falls.
    task automatic applyStimulus(input int i);
        @(negedge clock);
        ld_req           = vec[i].ldReq;
        ld_addr          = {vec[i].ldAddr1, vec[i].ldAddr0};
        st_req           = vec[i].stReq;
        st_addr          = vec[i].stAddr;
        st_data          = vec[i].stData;
        st_size          = vec[i].stSize;
        Dcache_valid_out = 1'b0;
        @(negedge clock);
        #1;
        checkOutput($sformatf("v%0d cmd", i),  64'(arb2Dcache_command), 64'(vec[i].expCmd));
        checkOutput($sformatf("v%0d addr", i), 64'(arb2Dcache_addr),    64'(vec[i].expAddr));
        checkOutput($sformatf("v%0d data", i), arb2Dcache_data,         vec[i].expData);
        checkOutput($sformatf("v%0d size", i), 64'(arb2Dcache_size),    64'(vec[i].expSize));
        Dcache_data_out  = vec[i].resp;
        Dcache_valid_out = 1'b1;
        #1;
        checkOutput($sformatf("v%0d ld_valid", i), 64'(ld_valid), 64'(vec[i].expLdValid));
        checkOutput($sformatf("v%0d st_ack", i),   64'(st_ack),   64'(vec[i].expAck));
        checkOutput($sformatf("v%0d ld_data", i),  ld_data,       vec[i].resp);
        @(negedge clock);
        ld_req           = '0;
        st_req           = 1'b0;
        Dcache_valid_out = 1'b0;
        #1;
        checkOutput($sformatf("v%0d busy after", i), 64'(busy), 64'd0);
    endtask

    // Zero-wait dcache model with requests left as driven: answers every
    // cycle a command is presented and logs completions (0/1 = load unit,
    // 2 = store). A missed event budget counts as a failed comparison.
    task automatic collectEvents(input int want);
        evCount = 0;
        for (int c = 0; c < 200 && evCount < want; c++) begin
            @(negedge clock);
            Dcache_data_out  = 64'hA5A5_0000_0000_5A5A + 64'(c);
            Dcache_valid_out = (arb2Dcache_command != 2'd0);
            #1;
            if (ld_valid == 2'b01) begin
                evLog[evCount] = 0;
                evCount = evCount + 1;
            end else if (ld_valid == 2'b10) begin
                evLog[evCount] = 1;
                evCount = evCount + 1;
            end else if (st_ack) begin
                evLog[evCount] = 2;
                evCount = evCount + 1;
            end
        end
        @(negedge clock);
        Dcache_valid_out = 1'b0;
        ld_req           = '0;
        st_req           = 1'b0;
        if (evCount < want) begin
            total = total + 1;
            bad   = bad + 1;
            $display("[TB] FAIL event timeout: got %0d events expected %0d", evCount, want);
        end
    endtask

    initial begin
        int rrExp[4];
        int stExp[6];

        // ld, a0, a1, st, st_addr, st_data, size, resp, cmd, addr, data, size, ldv, ack
        vec[0] = '{2'b01, 32'h104, 32'h200, 1'b0, 32'h0,  32'h0,        2'd0, 64'h1122334455667788,
                   2'd1, 32'h104, 64'h0,                   2'd2, 2'b01, 1'b0};
        vec[1] = '{2'b11, 32'h104, 32'h200, 1'b0, 32'h0,  32'h0,        2'd0, 64'h0102030405060708,
                   2'd1, 32'h200, 64'h0,                   2'd2, 2'b10, 1'b0};
        vec[2] = '{2'b11, 32'h104, 32'h200, 1'b0, 32'h0,  32'h0,        2'd0, 64'hF0E0D0C0B0A09080,
                   2'd1, 32'h104, 64'h0,                   2'd2, 2'b01, 1'b0};
        vec[3] = '{2'b00, 32'h0,   32'h0,   1'b1, 32'h8,  32'hDEADBEEF, 2'd2, 64'h0,
                   2'd2, 32'h8,   64'h00000000_DEADBEEF,   2'd2, 2'b00, 1'b1};
        vec[4] = '{2'b00, 32'h0,   32'h0,   1'b1, 32'hC,  32'hDEADBEEF, 2'd2, 64'h0,
                   2'd2, 32'hC,   64'hDEADBEEF_00000000,   2'd2, 2'b00, 1'b1};
        vec[5] = '{2'b10, 32'h0,   32'h200, 1'b1, 32'h10, 32'h12345678, 2'd0, 64'h5555AAAA5555AAAA,
                   2'd2, 32'h10,  64'h00000000_12345678,   2'd0, 2'b00, 1'b1};
        vec[6] = '{2'b10, 32'h0,   32'h200, 1'b0, 32'h0,  32'h0,        2'd0, 64'h0BADF00D0BADF00D,
                   2'd1, 32'h200, 64'h00000000_12345678,   2'd2, 2'b10, 1'b0};
        vec[7] = '{2'b10, 32'h0,   32'h2F0, 1'b0, 32'h0,  32'h0,        2'd0, 64'h7777666655554444,
                   2'd1, 32'h2F0, 64'h00000000_12345678,   2'd2, 2'b10, 1'b0};
        vec[8] = '{2'b00, 32'h0,   32'h0,   1'b1, 32'h14, 32'hCAFEF00D, 2'd1, 64'h0,
                   2'd2, 32'h14,  64'hCAFEF00D_00000000,   2'd1, 2'b00, 1'b1};
        vec[9] = '{2'b01, 32'h3FC, 32'h0,   1'b0, 32'h0,  32'h0,        2'd0, 64'h8899AABBCCDDEEFF,
                   2'd1, 32'h3FC, 64'hCAFEF00D_00000000,   2'd2, 2'b01, 1'b0};

        // Reset state.
        doReset();
        #1;
        checkOutput("reset cmd",      64'(arb2Dcache_command), 64'd0);
        checkOutput("reset addr",     64'(arb2Dcache_addr),    64'd0);
        checkOutput("reset data",     arb2Dcache_data,         64'd0);
        checkOutput("reset size",     64'(arb2Dcache_size),    64'd0);
        checkOutput("reset ld_valid", 64'(ld_valid),           64'd0);
        checkOutput("reset st_ack",   64'(st_ack),             64'd0);
        checkOutput("reset busy",     64'(busy),               64'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(i);
        end

        // Single load with two cycles of dcache latency.
        $display("[TB] single load, latency 2");
        doReset();
        ld_req  = 2'b01;
        ld_addr = {32'h0, 32'h104};
        @(negedge clock);
        #1;
        checkOutput("lat2 cmd",  64'(arb2Dcache_command), 64'd1);
        checkOutput("lat2 addr", 64'(arb2Dcache_addr),    64'h104);
        @(negedge clock);
        #1;
        checkOutput("lat2 no early valid", 64'(ld_valid), 64'd0);
        checkOutput("lat2 busy",           64'(busy),     64'd1);
        @(negedge clock);
        Dcache_data_out  = 64'h11223344_55667788;
        Dcache_valid_out = 1'b1;
        #1;
        checkOutput("lat2 ld_valid", 64'(ld_valid), 64'b01);
        checkOutput("lat2 ld_data",  ld_data,       64'h11223344_55667788);
        @(negedge clock);
        ld_req           = '0;
        Dcache_valid_out = 1'b0;
        #1;
        checkOutput("lat2 busy falls", 64'(busy), 64'd0);

        // Round-robin with both loads requesting continuously.
        $display("[TB] round-robin");
        doReset();
        ld_req  = 2'b11;
        ld_addr = {32'h200, 32'h100};
        collectEvents(4);
        rrExp = '{0, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            if (k < evCount) checkOutput($sformatf("rr grant %0d", k), 64'(evLog[k]), 64'(rrExp[k]));
        end

        // Starvation guard: four stores, then the waiting load, then stores.
        $display("[TB] starvation guard");
        doReset();
        st_req  = 1'b1;
        st_addr = 32'h40;
        st_data = 32'h13572468;
        st_size = 2'd2;
        ld_req  = 2'b10;
        ld_addr = {32'h300, 32'h0};
        collectEvents(6);
        stExp = '{2, 2, 2, 2, 1, 2};
        for (int k = 0; k < 6; k++) begin
            if (k < evCount) checkOutput($sformatf("starve event %0d", k), 64'(evLog[k]), 64'(stExp[k]));
        end

        // Squash before the response: drain without a pulse.
        $display("[TB] squash in LD_WAIT");
        doReset();
        ld_req  = 2'b01;
        ld_addr = {32'h0, 32'h180};
        @(negedge clock);
        squash = 1'b1;
        @(negedge clock);
        squash = 1'b0;
        ld_req = '0;
        #1;
        checkOutput("drain cmd",  64'(arb2Dcache_command), 64'd1);
        checkOutput("drain busy", 64'(busy),               64'd1);
        Dcache_valid_out = 1'b1;
        #1;
        checkOutput("drain no ld_valid", 64'(ld_valid), 64'd0);
        @(negedge clock);
        Dcache_valid_out = 1'b0;
        #1;
        checkOutput("drain idle busy", 64'(busy),               64'd0);
        checkOutput("drain idle cmd",  64'(arb2Dcache_command), 64'd0);

        // Squash together with the response: dropped, straight to IDLE.
        $display("[TB] squash with response");
        ld_req = 2'b10;
        ld_addr = {32'h1C0, 32'h0};
        @(negedge clock);
        squash           = 1'b1;
        Dcache_valid_out = 1'b1;
        #1;
        checkOutput("sqv no ld_valid", 64'(ld_valid), 64'd0);
        @(negedge clock);
        squash           = 1'b0;
        Dcache_valid_out = 1'b0;
        ld_req           = '0;
        #1;
        checkOutput("sqv busy", 64'(busy), 64'd0);

        // Squash while idle blocks the load grant for that cycle.
        $display("[TB] squash in IDLE");
        ld_req = 2'b01;
        squash = 1'b1;
        @(negedge clock);
        ld_req = '0;
        squash = 1'b0;
        #1;
        checkOutput("idle squash busy", 64'(busy), 64'd0);

        // Squash during a store is ignored.
        $display("[TB] squash in ST_WAIT");
        st_req  = 1'b1;
        st_addr = 32'h20;
        st_data = 32'h0000ABCD;
        st_size = 2'd2;
        @(negedge clock);
        squash           = 1'b1;
        Dcache_valid_out = 1'b1;
        #1;
        checkOutput("st squash ack", 64'(st_ack), 64'd1);
        @(negedge clock);
        squash           = 1'b0;
        Dcache_valid_out = 1'b0;
        st_req           = 1'b0;

        // Reset in the middle of a load.
        $display("[TB] reset mid-access");
        doReset();
        ld_req  = 2'b01;
        ld_addr = {32'h0, 32'h0AC};
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("midreset cmd",  64'(arb2Dcache_command), 64'd0);
        checkOutput("midreset busy", 64'(busy),               64'd0);
        checkOutput("midreset addr", 64'(arb2Dcache_addr),    64'd0);
        @(negedge clock);
        reset            = 1'b1;
        ld_req           = '0;
        Dcache_valid_out = 1'b1;
        #1;
        checkOutput("midreset stale valid", 64'(ld_valid), 64'd0);
        @(negedge clock);
        Dcache_valid_out = 1'b0;
        ld_req           = 2'b11;
        ld_addr          = {32'h222, 32'h111};
        @(negedge clock);
        #1;
        checkOutput("midreset rr_ptr", 64'(arb2Dcache_addr), 64'h111);
        Dcache_valid_out = 1'b1;
        #1;
        checkOutput("midreset grant0", 64'(ld_valid), 64'b01);
        @(negedge clock);
        Dcache_valid_out = 1'b0;
        ld_req           = '0;

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single dcache request port between NUM_LD load functional units and the store path. Committed stores take priority; loads are served round-robin; a starvation guard limits consecutive store grants.
- Sits between the execute-stage load/store units and the dcache.
- Holds one outstanding dcache access at a time and routes the response back to the granted requester.
- Aborts in-flight loads on squash.

Parameters:
- NUM_LD, 2, number of load requesters (power of two, ≥2).
- XLEN, 32, address/data word width.
- STARVE_LIMIT, 4, max consecutive store grants while any load is waiting.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset.
- ld_req  in  NUM_LD  per-load request; held high until that unit sees its ld_valid.
- ld_addr  in  NUM_LD*XLEN  per-load byte address; slice i = [i*XLEN +: XLEN].
- st_req  in  1  store request; held high until st_ack.
- st_addr  in  XLEN  store byte address.
- st_data  in  XLEN  store word.
- st_size  in  2  MEM_SIZE: BYTE/HALF/WORD.
- squash  in  1  pipeline flush; kills an in-flight load.
- Dcache_data_out  in  64  dcache response doubleword.
- Dcache_valid_out  in  1  dcache access complete, for both load and store.
- arb2Dcache_command  out  2  0=NONE, 1=LOAD, 2=STORE.
- arb2Dcache_addr  out  XLEN  access address.
- arb2Dcache_data  out  64  store doubleword.
- arb2Dcache_size  out  2  access size.
- ld_data  out  64  Dcache_data_out passed through combinationally to all loads.
- ld_valid  out  NUM_LD  one-hot, 1-cycle pulse, indicating completion for load i.
- st_ack  out  1  1-cycle pulse, indicating store complete.
- busy  out  1  state != IDLE.

Behaviour:
- Reset, asynchronous on reset=0:
  - state=IDLE, rr_ptr=0, st_streak=0, grant index=0.
  - arb2Dcache_command=NONE; arb2Dcache_addr, arb2Dcache_data, arb2Dcache_size = 0.
  - ld_valid=0, st_ack=0, busy=0.
  - Reset mid-access abandons the access; any later Dcache_valid_out while IDLE is ignored.
- FSM states: IDLE, LD_WAIT, ST_WAIT, DRAIN.
- IDLE: winner is selected combinationally from ld_req/st_req and registered at the next edge.
  - Winner load i: latch i, ld_addr[i], size=WORD → LD_WAIT.
  - Winner store: latch st_addr, st_data (positioned), st_size → ST_WAIT.
  - No request: stay IDLE; command=NONE.
- Winner selection:
  - Store wins if st_req, unless (st_streak==STARVE_LIMIT and |ld_req).
  - Otherwise the first ld_req[j] at or after rr_ptr, scanning upward modulo NUM_LD.
- Counter updates:
  - Load grant: rr_ptr ← (i+1) mod NUM_LD; st_streak ← 0.
  - Store grant with |ld_req: st_streak ← st_streak+1, saturating at STARVE_LIMIT.
  - Store grant with no load waiting: st_streak ← 0.
- LD_WAIT:
  - command=LOAD, addr/size held from registers.
  - On Dcache_valid_out: ld_valid[i]=1 the same cycle, ld_data=Dcache_data_out; → IDLE.
- ST_WAIT:
  - command=STORE.
  - arb2Dcache_data = addr[2] ? {st_data, 32'b0} : {32'b0, st_data}.
  - On Dcache_valid_out: st_ack=1 the same cycle; → IDLE.
- Latency and throughput:
  - Request visible at edge t → command driven from t+1.
  - Response pulse in the Dcache_valid_out cycle.
  - At least one IDLE cycle between accesses (requester drops req after its pulse).
  - Minimum access cost: 2 cycles plus dcache latency.
- Squash:
  - In LD_WAIT: → DRAIN.
  - In IDLE: suppresses load grants that cycle; stores may still be granted.
  - In ST_WAIT or DRAIN: ignored. Committed stores always complete.
- DRAIN:
  - command=LOAD held, so the dcache finishes the access.
  - On Dcache_valid_out: no ld_valid pulse; → IDLE.
- Squash and Dcache_valid_out in the same LD_WAIT cycle: the response is dropped (no ld_valid); → IDLE.
- Requester drops ld_req mid LD_WAIT without squash: the access completes and the pulse is still issued (harmless).
- Dcache_valid_out in IDLE: ignored.
- Outputs with command=NONE: addr, data and size keep their last values.

Test Plan:
- Single load: ld_req=01, ld_addr[0]=0x104; dcache returns 64'h11223344_55667788 two cycles after command → command=LOAD, addr=0x104 from next cycle; ld_valid=01 and ld_data=11223344_55667788 in the return cycle; busy falls the cycle after.
- Round-robin: both ld_req held continuously, dcache latency 1 → grant order 0,1,0,1; no load starves.
- Starvation: st_req and ld_req[1] held continuously, STARVE_LIMIT=4 → 4 st_acks, then ld_valid=10, then st_streak=0 and stores resume.
- Store positioning:
  - st_addr=0x8, st_data=0xDEADBEEF, WORD → arb2Dcache_data=0x00000000_DEADBEEF.
  - st_addr=0xC → arb2Dcache_data=0xDEADBEEF_00000000, size=WORD.
- Squash: squash pulse in LD_WAIT before the response → state DRAIN, command stays LOAD; at response no ld_valid; IDLE next cycle. Squash during ST_WAIT → st_ack still issued.
- Reset mid-access: reset=0 in LD_WAIT → command=NONE and busy=0 immediately (asynchronous); a subsequent Dcache_valid_out produces no ld_valid; rr_ptr=0.
